// File: rtl/eth_header_pkg.sv
// Shared types and constants for the Ethernet header transmitter and the receive parser.
package eth_header_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DST  = 3'd3,
        SRC  = 3'd4,
        TL   = 3'd5,
        IFG  = 3'd6
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int DST_LEN = 6;
    localparam int SRC_LEN = 6;
    localparam int TL_LEN  = 2;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] tl;
    } hdr_fields_t;

    // Index 0 selects the most significant byte, which goes on the wire first.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = mac[47:40];
            4'd1:    b = mac[39:32];
            4'd2:    b = mac[31:24];
            4'd3:    b = mac[23:16];
            4'd4:    b = mac[15:8];
            4'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] tl_byte(input logic [15:0] tl, input logic [3:0] idx);
        return (idx == 4'd0) ? tl[15:8] : tl[7:0];
    endfunction

endpackage

// File: rtl/eth_byte_mux.sv
// Combinational selection of the header byte for a given state and byte index.
module eth_byte_mux
    import eth_header_pkg::*;
(
    input  state_t      state,
    input  logic [3:0]  cnt,
    input  hdr_fields_t fields,
    output logic [7:0]  byte_out
);

    always_comb begin
        byte_out = 8'h00;
        case (state)
            PRE:     byte_out = PREAMBLE_BYTE;
            SFD:     byte_out = SFD_BYTE;
            DST:     byte_out = mac_byte(fields.dst, cnt);
            SRC:     byte_out = mac_byte(fields.src, cnt);
            TL:      byte_out = tl_byte(fields.tl, cnt);
            default: byte_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/eth_header_tx.sv
// Serialises preamble, SFD, destination, source and type/length onto a valid/ready byte stream.
// Optional inter-frame gap state is built when ETH_HEADER_TX_IFG_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, no byte offered
// PRE   | sending PREAMBLE_LEN x 0x55
// SFD   | sending 0xD5
// DST   | sending destination address, MSB first
// SRC   | sending source address, MSB first
// TL    | sending type/length, MSB first
// IFG   | busy gap of IFG_CYCLES after the header (optional)
module eth_header_tx
    import eth_header_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start,
    input  logic [47:0] dst_addr,
    input  logic [47:0] src_addr,
    input  logic [15:0] type_length,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        preamble_sent,
    output logic        dst_addr_sent,
    output logic        src_addr_sent,
    output logic        type_length_sent
);

    if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_bad_preamble_len
        $error("eth_header_tx: PREAMBLE_LEN must be 1..15");
    end
    if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_ifg_cycles
        $error("eth_header_tx: IFG_CYCLES must be 1..255");
    end

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0] DST_LAST = 4'(DST_LEN - 1);
    localparam logic [3:0] SRC_LAST = 4'(SRC_LEN - 1);
    localparam logic [3:0] TL_LAST  = 4'(TL_LEN - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    hdr_fields_t fields_q, fields_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        busy_q, busy_d;
    logic        preamble_sent_q, preamble_sent_d;
    logic        dst_addr_sent_q, dst_addr_sent_d;
    logic        src_addr_sent_q, src_addr_sent_d;
    logic        type_length_sent_q, type_length_sent_d;
    logic        xfer;
    logic [7:0]  byte_sel;

`ifdef ETH_HEADER_TX_IFG_EN
    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);
    logic [7:0] ifg_cnt_q, ifg_cnt_d;
`endif

    assign xfer = data_valid_q && data_ready;

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        fields_d           = fields_q;
        preamble_sent_d    = 1'b0;
        dst_addr_sent_d    = 1'b0;
        src_addr_sent_d    = 1'b0;
        type_length_sent_d = 1'b0;
`ifdef ETH_HEADER_TX_IFG_EN
        ifg_cnt_d          = ifg_cnt_q;
`endif

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = PRE;
                        cnt_d    = 4'd0;
                        fields_d = '{dst: dst_addr, src: src_addr, tl: type_length};
                    end
                end
                PRE: begin
                    if (xfer) begin
                        if (cnt_q == PRE_LAST) begin
                            state_d = SFD;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                SFD: begin
                    if (xfer) begin
                        state_d         = DST;
                        cnt_d           = 4'd0;
                        preamble_sent_d = 1'b1;
                    end
                end
                DST: begin
                    if (xfer) begin
                        if (cnt_q == DST_LAST) begin
                            state_d         = SRC;
                            cnt_d           = 4'd0;
                            dst_addr_sent_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                SRC: begin
                    if (xfer) begin
                        if (cnt_q == SRC_LAST) begin
                            state_d         = TL;
                            cnt_d           = 4'd0;
                            src_addr_sent_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                TL: begin
                    if (xfer) begin
                        cnt_d = 4'd0;
                        type_length_sent_d = 1'b0;
                        if (cnt_q == TL_LAST) begin
                            type_length_sent_d = 1'b1;
`ifdef ETH_HEADER_TX_IFG_EN
                            state_d   = IFG;
                            ifg_cnt_d = IFG_LAST;
`else
                            state_d   = IDLE;
`endif
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
`ifdef ETH_HEADER_TX_IFG_EN
                // Down-counter: leaves on terminal count after IFG_CYCLES cycles in IFG.
                IFG: begin
                    if (ifg_cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        ifg_cnt_d = ifg_cnt_q - 8'd1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        data_valid_d = (state_d == PRE) || (state_d == SFD) || (state_d == DST) ||
                       (state_d == SRC) || (state_d == TL);
        busy_d       = (state_d != IDLE);
        data_d       = byte_sel;
    end

    // Mux looks at next-state values so data is registered alongside data_valid.
    eth_byte_mux u_byte_mux (
        .state    (state_d),
        .cnt      (cnt_d),
        .fields   (fields_d),
        .byte_out (byte_sel)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            cnt_q              <= 4'd0;
            fields_q           <= '0;
            data_q             <= 8'h00;
            data_valid_q       <= 1'b0;
            busy_q             <= 1'b0;
            preamble_sent_q    <= 1'b0;
            dst_addr_sent_q    <= 1'b0;
            src_addr_sent_q    <= 1'b0;
            type_length_sent_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            fields_q           <= fields_d;
            data_q             <= data_d;
            data_valid_q       <= data_valid_d;
            busy_q             <= busy_d;
            preamble_sent_q    <= preamble_sent_d;
            dst_addr_sent_q    <= dst_addr_sent_d;
            src_addr_sent_q    <= src_addr_sent_d;
            type_length_sent_q <= type_length_sent_d;
        end
    end

`ifdef ETH_HEADER_TX_IFG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ifg_cnt_q <= 8'd0;
        end else begin
            ifg_cnt_q <= ifg_cnt_d;
        end
    end
`endif

    assign data             = data_q;
    assign data_valid       = data_valid_q;
    assign busy             = busy_q;
    assign preamble_sent    = preamble_sent_q;
    assign dst_addr_sent    = dst_addr_sent_q;
    assign src_addr_sent    = src_addr_sent_q;
    assign type_length_sent = type_length_sent_q;

endmodule

// File: tb/tb_eth_header_tx.sv
// Self-checking bench for eth_header_tx: literal vector table, random headers against a byte-list model, corner sequences.
module tb_eth_header_tx;

    localparam int IFG = 12;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        data_ready = 1'b0;
    logic [47:0] dst_addr = '0;
    logic [47:0] src_addr = '0;
    logic [15:0] type_length = '0;
    logic [7:0]  data;
    logic        data_valid, busy;
    logic        preamble_sent, dst_addr_sent, src_addr_sent, type_length_sent;

    int total = 0;
    int bad = 0;

    eth_header_tx #(.PREAMBLE_LEN(7), .IFG_CYCLES(IFG)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .start            (start),
        .dst_addr         (dst_addr),
        .src_addr         (src_addr),
        .type_length      (type_length),
        .data             (data),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .busy             (busy),
        .preamble_sent    (preamble_sent),
        .dst_addr_sent    (dst_addr_sent),
        .src_addr_sent    (src_addr_sent),
        .type_length_sent (type_length_sent)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Header as a byte list built straight from the field order, packed first-byte-most-significant.
    function automatic logic [175:0] model_hdr(input logic [47:0] d, input logic [47:0] s,
                                               input logic [15:0] t);
        logic [7:0]   q[$];
        logic [175:0] r;
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) q.push_back(d[8*i +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(s[8*i +: 8]);
        q.push_back(t[15:8]);
        q.push_back(t[7:0]);
        r = '0;
        foreach (q[i]) r = {r[167:0], q[i]};
        return r;
    endfunction

    function automatic logic pick_ready(input int mode, input int cyc);
        logic r;
        case (mode)
            0: r = 1'b1;
            1: r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: r = 1'($urandom_range(0, 1));
            default: r = ((cyc % 7) == 6);
        endcase
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        check("idle_wait busy", 64'(busy), 64'd0);
    endtask

    task automatic run_header(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int rmode, input bit inject, input logic [175:0] exp,
                              input string tag);
        logic [7:0] got[$];
        int         nx = 0;
        int         cyc = 0;
        bit         did = 0;
        logic       v, rdy;
        logic [7:0] dd;
        logic [3:0] es;
        wait_idle();
        dst_addr = d;
        src_addr = s;
        type_length = t;
        start = 1'b1;
        data_ready = pick_ready(rmode, 0);
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, " first_byte"}, 64'({data_valid, data, busy}), 64'({1'b1, 8'h55, 1'b1}));
        while (nx < 22 && cyc < 400) begin
            data_ready = pick_ready(rmode, cyc);
            if (inject && nx == 16 && !did) begin
                dst_addr = 48'hAAAAAAAAAAAA;
                start = 1'b1;
                did = 1;
            end else begin
                start = 1'b0;
            end
            v = data_valid;
            dd = data;
            rdy = data_ready;
            @(posedge clock); #1;
            cyc++;
            if (v && rdy) begin
                got.push_back(dd);
                nx++;
            end
            es = {v && rdy && nx == 8, v && rdy && nx == 14, v && rdy && nx == 20, v && rdy && nx == 22};
            check({tag, " strobes"},
                  64'({preamble_sent, dst_addr_sent, src_addr_sent, type_length_sent}), 64'(es));
            if (v && !rdy) check({tag, " stall_hold"}, 64'({data_valid, data}), 64'({1'b1, dd}));
        end
        start = 1'b0;
        check({tag, " byte_count"}, 64'(nx), 64'd22);
        foreach (got[i]) check($sformatf("%s byte%0d", tag, i), 64'(got[i]), 64'(exp[8*(21-i) +: 8]));
`ifdef ETH_HEADER_TX_IFG_EN
        check({tag, " end_state"}, 64'({busy, data_valid}), 64'({1'b1, 1'b0}));
`else
        check({tag, " end_state"}, 64'({busy, data_valid}), 64'({1'b0, 1'b0}));
`endif
    endtask

    typedef struct {
        logic [47:0]  d;
        logic [47:0]  s;
        logic [15:0]  t;
        int           rmode;
        logic [175:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, vseen;
        logic [47:0] rd, rs;
        logic [15:0] rt;

        tbl[0] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 0,
                   176'h55555555555555D5010203040506FFFEFDFCFBFA0800};
        tbl[1] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 1,
                   176'h55555555555555D5010203040506FFFEFDFCFBFA0800};
        tbl[2] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 2,
                   176'h55555555555555D5010203040506FFFEFDFCFBFA0800};
        tbl[3] = '{48'h123456789ABC, 48'h000000000000, 16'h86DD, 3,
                   176'h55555555555555D5123456789ABC00000000000086DD};
        tbl[4] = '{48'hFFFFFFFFFFFF, 48'h00A0C9112233, 16'h0042, 0,
                   176'h55555555555555D5FFFFFFFFFFFF00A0C91122330042};

        // Reset values
        #12;
        check("reset outputs",
              64'({data, data_valid, busy, preamble_sent, dst_addr_sent, src_addr_sent, type_length_sent}),
              64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        enable = 1'b1;
        @(posedge clock); #1;
        check("idle no valid", 64'({data_valid, busy}), 64'd0);

        foreach (tbl[i])
            run_header(tbl[i].d, tbl[i].s, tbl[i].t, tbl[i].rmode, 1'b0, tbl[i].exp,
                       $sformatf("vec%0d", i));

        for (int k = 0; k < 8; k++) begin
            rd = {16'($urandom), 32'($urandom)};
            rs = {16'($urandom), 32'($urandom)};
            rt = 16'($urandom);
            run_header(rd, rs, rt, 2, 1'b0, model_hdr(rd, rs, rt), $sformatf("rand%0d", k));
        end

        // Input change plus ignored start while in SRC
        run_header(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 0, 1'b1,
                   model_hdr(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800), "latch");
        vseen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (data_valid) vseen++;
        end
        check("latch no_second_header", 64'(vseen), 64'd0);

        // Abort during the 3rd destination byte
        wait_idle();
        dst_addr = 48'h010203040506;
        src_addr = 48'hFFFEFDFCFBFA;
        type_length = 16'h0800;
        data_ready = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        check("abort on_dst3", 64'({data_valid, data}), 64'({1'b1, 8'h03}));
        enable = 1'b0;
        @(posedge clock); #1;
        check("abort dropped",
              64'({data_valid, busy, preamble_sent, dst_addr_sent, src_addr_sent, type_length_sent}),
              64'd0);
        enable = 1'b1;
        run_header(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 0, 1'b0,
                   model_hdr(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800), "after_abort");

        // Back-to-back start in the type_length_sent cycle
        run_header(48'h0A0B0C0D0E0F, 48'h111213141516, 16'h88B5, 0, 1'b0,
                   model_hdr(48'h0A0B0C0D0E0F, 48'h111213141516, 16'h88B5), "b2b");
        check("b2b tl_sent", 64'(type_length_sent), 64'd1);
        start = 1'b1;
`ifdef ETH_HEADER_TX_IFG_EN
        n = 1;
        vseen = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (data_valid) vseen++;
            if (!busy) break;
            n++;
        end
        check("ifg busy_cycles", 64'(n), 64'(IFG));
        check("ifg no_valid", 64'(vseen), 64'd0);
`else
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b second_start", 64'({data_valid, data, busy}), 64'({1'b1, 8'h55, 1'b1}));
        data_ready = 1'b1;
`endif
        wait_idle();

        // Asynchronous reset mid-preamble
        data_ready = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        check("pre_reset in_pre", 64'({data_valid, data}), 64'({1'b1, 8'h55}));
        reset_n = 1'b0;
        #1;
        check("async_reset outputs", 64'({data, data_valid, busy}), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_reset idle", 64'({data_valid, busy}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
